// File: rtl/adc733_seq_ctrl.sv
// adc733_seq_ctrl
//   Sequencer for the 6-channel serial ADC port. On a start pulse it raises SE,
//   waits SE_DELAY cycles, shifts N_CFG control words out on SDIFS/SDI, then
//   enters RUN. In RUN it deserialises sample frames from SDOFS/SDO, tags each
//   with a round-robin channel index and presents it on a valid/ready stream.
//
// Optional feature (compile-time macro ADC733_CH_MASK_EN):
//   adds input ch_mask[N_CH-1:0]. A completed word whose channel bit is 0 is
//   discarded (no s_valid, no overrun); the channel counter still advances.
//
// Ports:
//   adc_clk        serial bit clock, all logic on its rising edge
//   rst_l          asynchronous active-low reset
//   start          one-cycle pulse, honoured only in IDLE
//   stop           one-cycle pulse, any non-IDLE state returns to IDLE
//   sync_req       one-cycle pulse, realigns channel numbering to 0
//   SE             serial port enable
//   SDIFS / SDI    control-word frame sync / data (MSB first)
//   SDOFS / SDO    sample frame sync / data from the ADC (MSB first)
//   s_data/s_ch    captured sample and its channel index
//   s_valid        sample valid, held until s_ready
//   s_ready        downstream ready
//   cfg_done       high in RUN
//   overrun        sticky, a word was dropped while s_valid was stalled
//   frame_err_cnt  saturating count of truncated frames
module adc733_seq_ctrl #(
    parameter int                N_CH     = 6,
    parameter int                WORD_W   = 16,
    parameter int                N_CFG    = 4,
    parameter logic [WORD_W-1:0] CFG_W0   = 16'h8000,
    parameter logic [WORD_W-1:0] CFG_W1   = 16'h8131,
    parameter logic [WORD_W-1:0] CFG_W2   = 16'h8203,
    parameter logic [WORD_W-1:0] CFG_W3   = 16'h8300,
    parameter int                SE_DELAY = 8
) (
    input  logic              adc_clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic              stop,
    input  logic              sync_req,
`ifdef ADC733_CH_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic              SE,
    output logic              SDIFS,
    output logic              SDI,
    input  logic              SDOFS,
    input  logic              SDO,
    output logic [WORD_W-1:0] s_data,
    output logic [2:0]        s_ch,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              cfg_done,
    output logic              overrun,
    output logic [7:0]        frame_err_cnt
);

    localparam int CW = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE, S_SE_WAIT, S_CFG_FS, S_CFG_SHIFT, S_CFG_GAP, S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          n_q, n_d;
    logic [WORD_W-1:0]   cfg_word, cfg_sh;

    logic                cap_act_q;
    logic [CW-1:0]       cap_cnt_q;
    logic [WORD_W-2:0]   shreg_q;
    logic                sync_pend_q, frame_sync_q;
    logic [2:0]          ch_q;
    logic [WORD_W-1:0]   s_data_q;
    logic [2:0]          s_ch_q;
    logic                s_valid_q, overrun_q;
    logic [7:0]          err_q;

    logic                run, frame_start, word_done, trunc, clr_stats;
    logic                mask_ok, drop, load;
    logic [2:0]          tag, ch_next;
    logic [WORD_W-1:0]   word;

    // ---------------- configuration FSM ----------------
    always_comb begin
        case (n_q)
            2'd0:    cfg_word = CFG_W0;
            2'd1:    cfg_word = CFG_W1;
            2'd2:    cfg_word = CFG_W2;
            default: cfg_word = CFG_W3;
        endcase
    end

    // Shift-cycle cnt_q carries bit WORD_W-2-cnt_q of the current word.
    assign cfg_sh = cfg_word << cnt_q;

    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        SE       = 1'b0;
        SDIFS    = 1'b0;
        SDI      = 1'b0;
        cfg_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_SE_WAIT;
            end
            S_SE_WAIT: begin
                SE = 1'b1;
                if (cnt_q == 8'(SE_DELAY - 1)) begin
                    state_d = S_CFG_FS;
                    cnt_d   = '0;
                    n_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CFG_FS: begin
                SE      = 1'b1;
                SDIFS   = 1'b1;
                SDI     = cfg_word[WORD_W-1];
                state_d = S_CFG_SHIFT;
                cnt_d   = '0;
            end
            S_CFG_SHIFT: begin
                SE  = 1'b1;
                SDI = cfg_sh[WORD_W-2];
                if (cnt_q == 8'(WORD_W - 2)) begin
                    state_d = S_CFG_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CFG_GAP: begin
                SE = 1'b1;
                if (cnt_q == 8'd1) begin
                    cnt_d = '0;
                    if (n_q == 2'(N_CFG - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        n_d     = n_q + 2'd1;
                        state_d = S_CFG_FS;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                SE       = 1'b1;
                cfg_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop && state_q != S_IDLE) state_d = S_IDLE;
    end

    // ---------------- frame capture ----------------
    assign run         = (state_q == S_RUN);
    assign frame_start = run && SDOFS;
    assign word_done   = run && cap_act_q && (cap_cnt_q == CW'(WORD_W - 1));
    // SDOFS on the bit-0 edge is a back-to-back frame, not a truncation.
    assign trunc       = run && cap_act_q && SDOFS && !word_done;
    assign word        = {shreg_q, SDO};
    assign clr_stats   = (state_q == S_IDLE) && start;

    // A sync request applies to the first frame whose SDOFS follows it; the
    // frame already in flight keeps its normal tag.
    assign tag     = frame_sync_q ? 3'd0 : ch_q;
    assign ch_next = (tag == 3'(N_CH - 1)) ? 3'd0 : tag + 3'd1;

`ifdef ADC733_CH_MASK_EN
    assign mask_ok = ch_mask[tag];
`else
    assign mask_ok = 1'b1;
`endif

    assign drop = word_done && mask_ok && s_valid_q && !s_ready;
    assign load = word_done && mask_ok && !drop;

    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            cap_act_q    <= 1'b0;
            cap_cnt_q    <= '0;
            shreg_q      <= '0;
            sync_pend_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            ch_q         <= '0;
            s_data_q     <= '0;
            s_ch_q       <= '0;
            s_valid_q    <= 1'b0;
            overrun_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            cap_act_q <= frame_start || (run && cap_act_q && !word_done);
            if (frame_start)    cap_cnt_q <= '0;
            else if (cap_act_q) cap_cnt_q <= cap_cnt_q + CW'(1);
            if (cap_act_q) shreg_q <= word[WORD_W-2:0];

            if (frame_start) begin
                // An aborted frame keeps its sync arming for the restart.
                frame_sync_q <= sync_pend_q || sync_req || (trunc && frame_sync_q);
                sync_pend_q  <= 1'b0;
            end else if (sync_req) begin
                sync_pend_q  <= 1'b1;
            end

            if (word_done) ch_q <= ch_next;

            if (load) begin
                s_data_q  <= word;
                s_ch_q    <= tag;
                s_valid_q <= 1'b1;
            end else if (s_valid_q && s_ready) begin
                s_valid_q <= 1'b0;
            end

            if (clr_stats)  overrun_q <= 1'b0;
            else if (drop)  overrun_q <= 1'b1;

            if (clr_stats)                err_q <= '0;
            else if (trunc && err_q != '1) err_q <= err_q + 8'd1;
        end
    end

    assign s_data        = s_data_q;
    assign s_ch          = s_ch_q;
    assign s_valid       = s_valid_q;
    assign overrun       = overrun_q;
    assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_adc733_seq_ctrl.sv
module tb_adc733_seq_ctrl;

    logic        adc_clk = 1'b0;
    logic        rst_l, start, stop, sync_req;
    logic        SE, SDIFS, SDI, SDOFS, SDO;
    logic [15:0] s_data;
    logic [2:0]  s_ch;
    logic        s_valid, s_ready, cfg_done, overrun;
    logic [7:0]  frame_err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state (frame/transaction level)
    int          m_ch    = 0;
    int          m_err   = 0;
    int          m_tag   = 0;
    bit          m_sync  = 0;
    bit          m_valid = 0;
    bit          m_ovr   = 0;
    logic [15:0] m_data  = '0;
    logic [15:0] cfg_exp [4];

    adc733_seq_ctrl dut (
        .adc_clk       (adc_clk),
        .rst_l         (rst_l),
        .start         (start),
        .stop          (stop),
        .sync_req      (sync_req),
        .SE            (SE),
        .SDIFS         (SDIFS),
        .SDI           (SDI),
        .SDOFS         (SDOFS),
        .SDO           (SDO),
        .s_data        (s_data),
        .s_ch          (s_ch),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_done      (cfg_done),
        .overrun       (overrun),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream();
        chk("s_valid", 32'(s_valid), 32'(m_valid));
        if (m_valid) begin
            chk("s_data", 32'(s_data), 32'(m_data));
            chk("s_ch", 32'(s_ch), 32'(m_tag));
        end
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
    endtask

    // One frame: random idle gap, SDOFS, then nbits data bits MSB first.
    // rb = s_ready during the frame body, rl = s_ready on the bit-0 cycle.
    task automatic send_frame(input logic [15:0] d, input int nbits,
                              input bit rb, input bit rl, input int sync_pos);
        int  gap;
        bit  fs;
        int  t;
        gap = int'($urandom_range(0, 3));
        s_ready = rb;
        for (int i = 0; i < gap; i++) begin
            SDOFS = 1'b0;
            SDO   = 1'($urandom);
            tick();
        end
        SDOFS = 1'b1;
        SDO   = 1'($urandom);
        tick();
        if (rb) m_valid = 0;
        fs     = m_sync;
        m_sync = 0;
        for (int b = 0; b < nbits; b++) begin
            SDOFS    = 1'b0;
            SDO      = d[15-b];
            sync_req = (b == sync_pos);
            if (b == 15) begin
                s_ready = rl;
                chk("valid_before_last_bit", 32'(s_valid), 32'(m_valid));
            end
            tick();
            sync_req = 1'b0;
            if (b == sync_pos) m_sync = 1;
        end
        if (nbits == 16) begin
            t    = fs ? 0 : m_ch;
            m_ch = (t + 1) % 6;
            if (m_valid && !rl) begin
                m_ovr = 1;
            end else begin
                m_valid = 1;
                m_data  = d;
                m_tag   = t;
            end
        end else begin
            // aborted at the next SDOFS; a pending sync still applies
            m_err  = (m_err >= 255) ? 255 : m_err + 1;
            m_sync = m_sync | fs;
        end
    endtask

    // SDOFS held high for n cycles: every cycle after the first, plus the
    // next frame's SDOFS, truncates the frame in progress.
    task automatic sdofs_storm(input int n);
        s_ready = 1'b1;
        SDOFS   = 1'b1;
        for (int i = 0; i < n; i++) begin
            SDO = 1'($urandom);
            tick();
        end
        SDOFS   = 1'b0;
        m_valid = 0;
        m_err   = (m_err + n > 255) ? 255 : m_err + n;
    endtask

    initial begin
        logic [15:0] word;
        int          n;
        int          fsc;

        cfg_exp[0] = 16'h8000;
        cfg_exp[1] = 16'h8131;
        cfg_exp[2] = 16'h8203;
        cfg_exp[3] = 16'h8300;

        rst_l = 1'b0; start = 1'b0; stop = 1'b0; sync_req = 1'b0;
        SDOFS = 1'b0; SDO = 1'b0; s_ready = 1'b1;
        #2;
        chk("rst_SE", 32'(SE), 0);
        chk("rst_SDIFS", 32'(SDIFS), 0);
        chk("rst_SDI", 32'(SDI), 0);
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_cfg_done", 32'(cfg_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_s_data", 32'(s_data), 0);
        chk("rst_s_ch", 32'(s_ch), 0);
        chk("rst_err", 32'(frame_err_cnt), 0);
        tick();
        rst_l = 1'b1;
        tick();
        tick();
        chk("idle_SE", 32'(SE), 0);

        // ---- configuration sequence ----
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("se_rise", 32'(SE), 1);
        chk("sdifs_early", 32'(SDIFS), 0);
        n = 0;
        while (SDIFS !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("se_to_sdifs", 32'(n), 8);
        for (int w = 0; w < 4; w++) begin
            word = '0;
            fsc  = 0;
            chk("fs_pos", 32'(SDIFS), 1);
            for (int b = 0; b < 16; b++) begin
                if (b > 0) begin
                    SDOFS = (w < 3) ? 1'($urandom) : 1'b0;
                    SDO   = 1'($urandom);
                    tick();
                end
                word = {word[14:0], SDI};
                fsc  = fsc + int'(SDIFS);
            end
            SDOFS = 1'b0;
            chk("cfg_word", 32'(word), 32'(cfg_exp[w]));
            chk("sdifs_count", 32'(fsc), 1);
            tick();
            chk("gap1_SDI", 32'(SDI), 0);
            chk("gap_cfg_done", 32'(cfg_done), 0);
            tick();
            chk("gap2_SDI", 32'(SDI), 0);
            tick();
        end
        chk("cfg_done", 32'(cfg_done), 1);
        chk("run_SDIFS", 32'(SDIFS), 0);

        // ---- free-flowing stream, 12 frames ----
        for (int i = 0; i < 12; i++) begin
            send_frame(16'h1000 + 16'(i), 16, 1'b1, 1'b1, -1);
            chk_stream();
        end

        // ---- handshake corner cases ----
        send_frame(16'($urandom), 16, 1'b1, 1'b0, -1);   // held
        chk_stream();
        send_frame(16'($urandom), 16, 1'b0, 1'b1, -1);   // accept + load same edge
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b0, -1);   // held
        chk_stream();
        send_frame(16'($urandom), 16, 1'b0, 1'b0, -1);   // dropped -> overrun
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);   // skips dropped channel
        chk_stream();

        // ---- sync_req ----
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, 7);    // mid-frame
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, 15);   // on completion edge
        chk_stream();
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();

        // ---- truncated frames ----
        send_frame(16'($urandom), 9, 1'b1, 1'b1, -1);
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();
        sdofs_storm(300);
        send_frame(16'($urandom), 16, 1'b1, 1'b1, -1);
        chk_stream();

        // ---- stop with a pending sample ----
        send_frame(16'($urandom), 16, 1'b0, 1'b0, -1);
        chk_stream();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_SE", 32'(SE), 0);
        chk("stop_cfg_done", 32'(cfg_done), 0);
        chk("stop_s_valid", 32'(s_valid), 32'(m_valid));
        chk("stop_s_data", 32'(s_data), 32'(m_data));
        s_ready = 1'b1;
        tick();
        m_valid = 0;
        chk("stop_drain", 32'(s_valid), 0);

        // ---- restart clears stats, then reset mid-shift ----
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ovr = 0;
        m_err = 0;
        chk("restart_overrun", 32'(overrun), 0);
        chk("restart_err", 32'(frame_err_cnt), 0);
        chk("restart_SE", 32'(SE), 1);
        n = 0;
        while (SDIFS !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("restart_se_to_sdifs", 32'(n), 8);
        for (int i = 0; i < 18; i++) tick();
        chk("fs_word1", 32'(SDIFS), 1);
        for (int i = 0; i < 7; i++) tick();
        chk("shift_bit8", 32'(SDI), 1);
        rst_l = 1'b0;
        #1;
        chk("midrst_SE", 32'(SE), 0);
        chk("midrst_SDIFS", 32'(SDIFS), 0);
        chk("midrst_SDI", 32'(SDI), 0);
        chk("midrst_s_valid", 32'(s_valid), 0);
        chk("midrst_s_ch", 32'(s_ch), 0);
        #2;
        rst_l = 1'b1;
        tick();
        tick();
        chk("post_rst_SE", 32'(SE), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
